// File: rtl/alu_seq.sv
// alu_seq: multi-cycle N-bit ALU with valid/ready handshakes and NZCV-style flags.
//
// The block accepts one operation at a time. Single-cycle opcodes produce their
// registered result one edge after acceptance. MUL runs an iterative shift-add
// unsigned multiply, one multiplier bit per cycle, so it adds no multiplier to
// the critical path. The result and flags stay constant while out_valid is high.
//
// Build option:
//   ALU_SEQ_MUL_EN - when defined, opcode 1000 is the iterative multiply.
//                    When undefined, there is no multiplier and no EXEC state,
//                    and 1000 behaves like any undefined opcode (latency 1).
//
// Ports:
//   clk       - clock; all state changes on the rising edge
//   reset     - asynchronous, active-low reset
//   in_valid  - a, b and alu_ctl are valid
//   in_ready  - block can accept an operation (high only in IDLE)
//   a, b      - N-bit operands
//   alu_ctl   - operation select (AND/OR/ADD/SUB/PASSB/MUL)
//   out_valid - y and flags are valid
//   out_ready - consumer accepts the result
//   y         - N-bit result
//   zero, negative, carry, overflow - flags for the registered y
module alu_seq #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   alu_ctl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         zero,
    output logic         negative,
    output logic         carry,
    output logic         overflow
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam int         CW       = $clog2(N + 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
        EXEC = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t       state_reg;
    logic         in_ready_reg;
    logic         out_valid_reg;
    logic [N-1:0] y_reg;
    logic         zero_reg;
    logic         negative_reg;
    logic         carry_reg;
    logic         overflow_reg;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs so the result
    // can be registered at the accepting edge.
    // ------------------------------------------------------------------
    logic [N:0]   sum_next;
    logic [N-1:0] res_next;
    logic         carry_next;
    logic         overflow_next;

    always_comb begin
        sum_next      = '0;
        res_next      = '0;
        carry_next    = 1'b0;
        overflow_next = 1'b0;
        case (alu_ctl)
            OP_AND:   res_next = a & b;
            OP_OR:    res_next = a | b;
            OP_PASSB: res_next = b;
            OP_ADD: begin
                sum_next      = {1'b0, a} + {1'b0, b};
                res_next      = sum_next[N-1:0];
                carry_next    = sum_next[N];
                overflow_next = (a[N-1] == b[N-1]) && (res_next[N-1] != a[N-1]);
            end
            OP_SUB: begin
                // a + ~b + 1: carry out is NOT borrow.
                sum_next      = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
                res_next      = sum_next[N-1:0];
                carry_next    = sum_next[N];
                overflow_next = (a[N-1] == ~b[N-1]) && (res_next[N-1] != a[N-1]);
            end
            default:  res_next = '1;  // undefined opcodes (and MUL when not built)
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // ------------------------------------------------------------------
    // Iterative multiply. {acc_hi, acc_lo} is a 2N-bit product register:
    // acc_lo starts as the multiplier and is consumed LSB first while the
    // partial product shifts in from the top. After N steps acc_lo holds
    // the low half (the result) and acc_hi the high half (overflow only).
    // ------------------------------------------------------------------
    logic [N-1:0]  mcand_reg;
    logic [N-1:0]  acc_hi_reg;
    logic [N-1:0]  acc_lo_reg;
    logic [CW-1:0] cnt_reg;
    logic [N:0]    mul_add;
    logic [N-1:0]  acc_hi_next;
    logic [N-1:0]  acc_lo_next;

    always_comb begin
        mul_add     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, mcand_reg} : '0);
        acc_hi_next = mul_add[N:1];
        acc_lo_next = {mul_add[0], acc_lo_reg[N-1:1]};
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered handshake outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            y_reg         <= '0;
            zero_reg      <= 1'b0;
            negative_reg  <= 1'b0;
            carry_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand_reg     <= '0;
            acc_hi_reg    <= '0;
            acc_lo_reg    <= '0;
            cnt_reg       <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_reg <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
                        if (alu_ctl == OP_MUL) begin
                            mcand_reg  <= a;
                            acc_hi_reg <= '0;
                            acc_lo_reg <= b;
                            cnt_reg    <= '0;
                            state_reg  <= EXEC;
                        end else
`endif
                        begin
                            y_reg         <= res_next;
                            zero_reg      <= (res_next == '0);
                            negative_reg  <= res_next[N-1];
                            carry_reg     <= carry_next;
                            overflow_reg  <= overflow_next;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                EXEC: begin
                    acc_hi_reg <= acc_hi_next;
                    acc_lo_reg <= acc_lo_next;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(N - 1)) begin
                        y_reg         <= acc_lo_next;
                        zero_reg      <= (acc_lo_next == '0);
                        negative_reg  <= acc_lo_next[N-1];
                        carry_reg     <= 1'b0;
                        overflow_reg  <= (acc_hi_next != '0);
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign y         = y_reg;
    assign zero      = zero_reg;
    assign negative  = negative_reg;
    assign carry     = carry_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N = 64). Directed cases plus randomized
// operations, checked against an arithmetic reference model.
module tb_alu_seq;

    localparam int N = 64;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [3:0]   alu_ctl = 4'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] y;
    logic         zero;
    logic         negative;
    logic         carry;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    alu_seq #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_ctl   (alu_ctl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: returns {y, zero, negative, carry, overflow}.
    function automatic logic [67:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                          input logic [3:0] op);
        logic [63:0]         r;
        logic                c;
        logic                v;
        logic [64:0]         s;
        logic signed [65:0]  exact;
        logic [127:0]        p;
        r = '1; c = 1'b0; v = 1'b0;
        case (op)
            4'b0000: r = ma & mb;
            4'b0001: r = ma | mb;
            4'b0111: r = mb;
            4'b0010: begin
                s = {1'b0, ma} + {1'b0, mb};
                r = s[63:0];
                c = s[64];
                exact = $signed({{2{ma[63]}}, ma}) + $signed({{2{mb[63]}}, mb});
                v = (exact != $signed({{2{r[63]}}, r}));
            end
            4'b0110: begin
                r = ma - mb;
                c = (ma >= mb);
                exact = $signed({{2{ma[63]}}, ma}) - $signed({{2{mb[63]}}, mb});
                v = (exact != $signed({{2{r[63]}}, r}));
            end
            4'b1000: begin
                if (MUL_EN) begin
                    p = {64'd0, ma} * {64'd0, mb};
                    r = p[63:0];
                    v = (p[127:64] != 64'd0);
                end
            end
            default: ;
        endcase
        return {r, (r == 64'd0), r[63], c, v};
    endfunction

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return {32'd0, $urandom()};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // One complete transaction: accept, wait for result (bounded), check
    // latency/result/flags, optionally stall with in_valid pulses, hand off.
    task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_, input logic [3:0] ctl,
                          input int stall);
        logic [67:0] exp;
        int          lat;
        int          exp_lat;
        bit          busy_bad;
        bit          hold_bad;
        exp     = model(ta, tb_, ctl);
        exp_lat = (MUL_EN && ctl == 4'b1000) ? N + 1 : 1;
        @(negedge clk);
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        a = ta; b = tb_; alu_ctl = ctl; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        busy_bad = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_bad = 1'b1;
            in_valid = $urandom_range(0, 1);
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_valid = 1'b0;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("in_ready_busy", {63'd0, busy_bad | in_ready}, 64'd0);
        check("y", y, exp[67:4]);
        check("flags_zncv", {60'd0, zero, negative, carry, overflow}, {60'd0, exp[3:0]});
        if (stall > 0) begin
            hold_bad = 1'b0;
            for (int i = 0; i < stall; i++) begin
                a = {$urandom(), $urandom()};
                b = {$urandom(), $urandom()};
                alu_ctl = 4'b0111;
                in_valid = 1'b1;
                @(posedge clk);
                @(negedge clk);
                in_valid = 1'b0;
                if (!out_valid || y !== exp[67:4] ||
                    {zero, negative, carry, overflow} !== exp[3:0] || in_ready)
                    hold_bad = 1'b1;
            end
            check("stall_hold", {63'd0, hold_bad}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("handoff", {62'd0, out_valid, in_ready}, 64'd1);
        $display("op ctl=%b a=%h b=%h y=%h zncv=%b%b%b%b lat=%0d stall=%0d",
                 ctl, ta, tb_, exp[67:4], exp[3], exp[2], exp[1], exp[0], lat, stall);
    endtask

    initial begin
        logic [3:0] ops [12];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000,
                4'b1000, 4'b0010, 4'b0110, 4'b0011, 4'b1101, 4'b1111};

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_y", y, 64'd0);
        check("rst_flags", {60'd0, zero, negative, carry, overflow}, 64'd0);
        reset = 1'b1;

        // Directed cases
        run_op(64'h0000_0000_000F_F000, 64'h0000_0000_0FF0_0000, 4'b0110, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 0);
        run_op(64'h8000_0000_0000_0000, 64'd1, 4'b0110, 0);
        run_op(64'd5, 64'd5, 4'b0110, 0);
        run_op(64'h0000_0000_1234_5678, 64'h10, 4'b1000, 0);
        run_op(64'h8000_0000_0000_0000, 64'd2, 4'b1000, 0);
        run_op(64'h0000_0000_1234_5678, 64'h0000_0000_1111_1111, 4'b0000, 5);
        run_op(64'h0000_0000_ABCD_1459, 64'h0000_0000_0432_8C1B, 4'b1101, 0);

        // Reset pulsed while an operation is in flight (EXEC with MUL, else DONE)
        @(negedge clk);
        a = 64'h1234; b = 64'h5678; alu_ctl = 4'b1000; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_y", y, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        run_op(64'd0, 64'h0000_0000_8765_4321, 4'b0111, 0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(rand_operand(), rand_operand(), ops[$urandom_range(0, 11)],
                   int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
